clk_div_bank: RTL
=================

// Module: clk_div_bank
// PURPOSE
//  Parametrised bank of NUM_OUT clock dividers driven from clk16f.
//  - Each channel has a half-period programmable at runtime.
//  - Channel changes are glitch-free: they take effect only at a period boundary.
//  - Each channel has its own enable with park-high.
//  - A global resync aligns the phase of all channels.
//  - Each channel produces a one-cycle rise strobe in the clk16f domain.
//  Feeds the serializer/deserializer clock tree. Defaults reproduce 4f/2f/f from 16f.
// PARAMETERS
//  NUM_OUT  3  number of divided clock channels (1..8)
//  DIV_W    4  half-period register width; legal half-periods 1..2^DIV_W-1
//  CH_W     $clog2(NUM_OUT) (localparam, min 1)  channel select width
// PORTS
//  clk16f    in   1        reference clock; all logic on posedge
//  reset_L   in   1        asynchronous, active-low reset
//  en        in   NUM_OUT  per-channel run enable
//  sync      in   1        single-cycle pulse: realign all channels
//  cfg_wr    in   1        single-cycle pulse: write cfg_half into channel cfg_ch
//  cfg_ch    in   CH_W     target channel of cfg_wr
//  cfg_half  in   DIV_W    new half-period in clk16f cycles
//  cfg_busy  out  NUM_OUT  pending cfg not yet applied, per channel
//  cfg_err   out  1        one-cycle pulse: rejected write (cfg_half==0 or cfg_ch>=NUM_OUT)
//  clk_out   out  NUM_OUT  divided clocks, registered
//  rise_stb  out  NUM_OUT  high for the single cycle in which clk_out[i] goes 0->1
//  running   out  NUM_OUT  channel is in RUN state
// BEHAVIOUR
//  Reset (async, immediate):
//   - clk_out=all 1; rise_stb=0; cfg_busy=0; cfg_err=0; running=0.
//   - cnt=0; state=PARKED; half[i]=2^(i+1), i.e. 2,4,8 by default.
//   - A reset mid-period truncates the period with no further strobe.
//  Per channel, two states:
//   - PARKED: clk_out=1, cnt=0.
//   - RUN: performs one count step per cycle.
//  Count step:
//   - If cnt==half-1: clk_out toggles and cnt<=0.
//   - Otherwise: cnt<=cnt+1.
//   - Output period = 2*half cycles, 50% duty cycle, first fall after `half` cycles.
//  State transitions:
//   - PARKED->RUN: in any cycle with en[i]=1; the count step is executed in that same cycle.
//     With en tied high, cycle k after reset release matches the legacy 4f/2f/f waveforms.
//   - RUN->PARKED: only at a period boundary (the 0->1 toggle cycle) while en[i]=0.
//     Dropping en mid-period completes the current period; a low never gets cut short.
//  rise_stb:
//   - Registered together with clk_out.
//   - Never asserted on reset, on park, or by sync.
//  Config:
//   - Accepted cfg_wr loads pending[ch] and sets cfg_busy[ch] from the next cycle.
//   - A new cfg_wr to a busy channel overwrites pending (last write wins).
//   - RUN channel: pending is applied at the next period boundary.
//     The boundary cycle still completes the old period; the new half governs from cnt=0 onward.
//     cfg_busy clears in the cycle after the boundary.
//   - PARKED channel: pending is applied in the cycle after the write.
//   - Rejected write: half and pending unchanged, cfg_err pulses, cfg_busy unchanged.
//  sync:
//   - Every RUN channel: cnt<=0, clk_out<=1; state remains RUN; all pending applied.
//   - A cfg_wr in the same cycle as sync is applied by that sync.
//   - All RUN channels then fall together after their own half cycles.
//   - Park requests are evaluated at the next boundary.
//  Simultaneous events:
//   - en 0->1 in the same cycle as a sync: the channel enters RUN at cnt=0 (sync wins over the count step).
// STRUCTURE
//  - Shared include clk_div_pkg.vh: DIV_W default, state encodings ST_PARKED/ST_RUN, default-half function.
//  - Sub-module clk_div_channel (one instance per channel via generate).
//    Holds cnt, half, pending, state and the clk_out/rise_stb registers.
//  - Top level holds cfg decode and cfg_err only.
// TESTING
//  1. Reset release, en=3'b111, no cfg:
//     - clk_out[0] period 4, clk_out[1] period 8, clk_out[2] period 16.
//     - All fall at cycles 2/4/8 after release.
//     - rise_stb[0] first high at cycle 4.
//  2. cfg_wr ch0 half=3 mid-low-phase:
//     - cfg_busy[0] high until the boundary.
//     - The old period completes, then period 6 with a 3/3 duty cycle; no runt pulse.
//  3. en[1] dropped at cnt=1 of the low phase:
//     - The low phase completes, clk_out[1] rises and stays 1, running[1]=0.
//     - Re-enable: fall after 4 cycles.
//  4. cfg_wr half=0 or cfg_ch=3 (NUM_OUT=3):
//     - cfg_err pulses one cycle; waveforms unchanged.
//  5. sync after channels have drifted (different halves):
//     - All RUN outputs are 1 the next cycle; channel i falls at cycle half[i].
//     - No rise_stb is asserted by the sync.
//  6. reset_L asserted mid-period, asynchronous to clk16f:
//     - Outputs go to reset values without waiting for a clock edge.
//     - After release, the test-1 waveforms repeat exactly.

Source files
------------

// File: rtl/clk_div_bank_pkg.sv
// ============================================================================
//  Module      : clk_div_bank_pkg
//  Description : Shared constants, channel state encoding and reset-value
//                helper for the clk_div_bank divider bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_bank_pkg;

    // Default half-period register width.
    localparam int DIV_W_DEFAULT = 4;

    // Channel state encoding, explicit one-bit width.
    typedef logic [0:0] ch_state_t;
    localparam ch_state_t ST_PARKED = 1'b0;
    localparam ch_state_t ST_RUN    = 1'b1;

    // Reset half-period of channel idx: 2^(idx+1), clamped to the largest
    // value a div_w-bit register can hold so wide banks stay legal.
    function automatic int default_half(input int idx, input int div_w);
        int lim;
        int h;
        lim = (1 << div_w) - 1;
        if (idx >= 30) begin
            h = lim;
        end else begin
            h = 1 << (idx + 1);
        end
        if (h > lim) begin
            h = lim;
        end
        return h;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_bank_channel.sv
// ============================================================================
//  Module      : clk_div_bank_channel
//  Description : One divided-clock channel. Holds the period counter, the
//                active and pending half-period, the PARKED/RUN state and the
//                registered clk_out / rise strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_bank_channel
    import clk_div_bank_pkg::*;
#(
    parameter int               DIV_W    = DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] RST_HALF = DIV_W'(2)
) (
    input  logic             clk16f_i,
    input  logic             reset_L_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_half_i,
    output logic             busy_o,
    output logic             clk_out_o,
    output logic             rise_stb_o,
    output logic             running_o
);

    ch_state_t        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;
    logic             stb_q, stb_d;

    logic [DIV_W-1:0] eff_half;
    logic             at_end;
    logic             step;
    logic             boundary;
    logic             do_sync;
    logic             apply;

    // Event decode. A parked channel is always sitting on a period boundary,
    // so a pending half governs its very first count step.
    always_comb begin
        eff_half = ((state_q == ST_PARKED) && busy_q) ? pend_q : half_q;
        at_end   = (cnt_q == (eff_half - DIV_W'(1)));
        step     = (state_q == ST_RUN) || en_i;
        boundary = (state_q == ST_RUN) && at_end && !clk_q;
        do_sync  = sync_i && step;
        apply    = busy_q && (sync_i || (state_q == ST_PARKED) || boundary);
    end

    // State register.
    always_ff @(posedge clk16f_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            state_q <= ST_PARKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on enable, park only on a rising boundary; sync holds RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PARKED: if (en_i) state_d = ST_RUN;
            ST_RUN:    if (!sync_i && boundary && !en_i) state_d = ST_PARKED;
            default:   state_d = ST_PARKED;
        endcase
    end

    // Outputs are pure register taps.
    always_comb begin
        busy_o     = busy_q;
        clk_out_o  = clk_q;
        rise_stb_o = stb_q;
        running_o  = (state_q == ST_RUN);
    end

    // Datapath next values: count step, sync realign, pending half handling.
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        stb_d  = 1'b0;
        half_d = half_q;
        pend_d = pend_q;
        busy_d = busy_q;
        if (do_sync) begin
            cnt_d = '0;
            clk_d = 1'b1;
        end else if (step) begin
            if (at_end) begin
                cnt_d = '0;
                clk_d = ~clk_q;
                // A rise that parks the channel is not a new period.
                stb_d = boundary && en_i;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end else begin
            cnt_d = '0;
            clk_d = 1'b1;
        end
        if (apply) begin
            half_d = pend_q;
            busy_d = 1'b0;
        end
        // A write in the sync cycle takes effect through that same sync.
        if (wr_i) begin
            pend_d = wr_half_i;
            if (sync_i) begin
                half_d = wr_half_i;
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk16f_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            cnt_q  <= '0;
            half_q <= RST_HALF;
            pend_q <= RST_HALF;
            busy_q <= 1'b0;
            clk_q  <= 1'b1;
            stb_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            clk_q  <= clk_d;
            stb_q  <= stb_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clk_div_bank.sv
// ============================================================================
//  Module      : clk_div_bank
//  Description : Bank of NUM_OUT glitch-free programmable clock dividers
//                running from clk16f. Top level decodes configuration writes
//                and flags rejected ones; all timing lives in the channels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter  int NUM_OUT = 3,
    parameter  int DIV_W   = DIV_W_DEFAULT,
    localparam int CH_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic               clk16f_i,
    input  logic               reset_L_i,
    input  logic [NUM_OUT-1:0] en_i,
    input  logic               sync_i,
    input  logic               cfg_wr_i,
    input  logic [CH_W-1:0]    cfg_ch_i,
    input  logic [DIV_W-1:0]   cfg_half_i,
    output logic [NUM_OUT-1:0] cfg_busy_o,
    output logic               cfg_err_o,
    output logic [NUM_OUT-1:0] clk_out_o,
    output logic [NUM_OUT-1:0] rise_stb_o,
    output logic [NUM_OUT-1:0] running_o
);

    localparam int unsigned NUM_OUT_U = NUM_OUT;

    logic cfg_ok;
    logic cfg_err_q, cfg_err_d;

    // Accept a write only for an existing channel and a non-zero half-period.
    always_comb begin
        cfg_ok    = cfg_wr_i && (cfg_half_i != '0) && (32'(cfg_ch_i) < NUM_OUT_U);
        cfg_err_d = cfg_wr_i && !cfg_ok;
    end

    // Rejected-write flag, one-cycle pulse.
    always_ff @(posedge clk16f_i or negedge reset_L_i) begin
        if (!reset_L_i) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err_o = cfg_err_q;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_ch
        logic ch_wr;
        assign ch_wr = cfg_ok && (cfg_ch_i == CH_W'(gi));

        clk_div_bank_channel #(
            .DIV_W    (DIV_W),
            .RST_HALF (DIV_W'(default_half(gi, DIV_W)))
        ) u_ch (
            .clk16f_i   (clk16f_i),
            .reset_L_i  (reset_L_i),
            .en_i       (en_i[gi]),
            .sync_i     (sync_i),
            .wr_i       (ch_wr),
            .wr_half_i  (cfg_half_i),
            .busy_o     (cfg_busy_o[gi]),
            .clk_out_o  (clk_out_o[gi]),
            .rise_stb_o (rise_stb_o[gi]),
            .running_o  (running_o[gi])
        );
    end

endmodule

`default_nettype wire
